// File: rtl/rv32im_pkg.sv
// Shared RV32IM definitions: M-extension ALU control codes, mul/div FSM
// state type and the architectural word width.
package rv32im_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] ALU_MUL     = 5'b01010;
  localparam logic [4:0] ALU_MULH    = 5'b01011;
  localparam logic [4:0] ALU_MULHSU  = 5'b01100;
  localparam logic [4:0] ALU_MULHU   = 5'b01101;
  localparam logic [4:0] ALU_DIV     = 5'b01110;
  localparam logic [4:0] ALU_DIVU    = 5'b01111;
  localparam logic [4:0] ALU_REM     = 5'b10000;
  localparam logic [4:0] ALU_REMU    = 5'b10001;
  localparam logic [4:0] ALU_INVALID = 5'b11111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } muldiv_state_t;

  // True for the eight codes handled by the multiply/divide unit.
  function automatic logic is_muldiv_code(input logic [4:0] code);
    return (code >= ALU_MUL) && (code <= ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_sign_prep.sv
// Operand preparation for the mul/div unit: decodes the op code into
// datapath selects, derives the effective operand signs and returns the
// magnitudes the unsigned iterative datapath works on.
module muldiv_sign_prep
  import rv32im_pkg::*;
(
  input  logic [4:0]      alu_ctrl_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            valid_o,
  output logic            is_mul_o,
  output logic            is_rem_o,
  output logic            high_word_o,
  output logic            signed1_o,
  output logic            signed2_o,
  output logic            neg_result_o,
  output logic [XLEN-1:0] abs1_o,
  output logic [XLEN-1:0] abs2_o
);

  logic neg1_s;
  logic neg2_s;

  // Decode op code into datapath selects and operand signedness.
  always_comb begin
    valid_o     = is_muldiv_code(alu_ctrl_i);
    is_mul_o    = 1'b0;
    is_rem_o    = 1'b0;
    high_word_o = 1'b0;
    signed1_o   = 1'b0;
    signed2_o   = 1'b0;
    case (alu_ctrl_i)
      ALU_MUL: begin
        is_mul_o = 1'b1;
      end
      ALU_MULH: begin
        is_mul_o    = 1'b1;
        high_word_o = 1'b1;
        signed1_o   = 1'b1;
        signed2_o   = 1'b1;
      end
      ALU_MULHSU: begin
        is_mul_o    = 1'b1;
        high_word_o = 1'b1;
        signed1_o   = 1'b1;
      end
      ALU_MULHU: begin
        is_mul_o    = 1'b1;
        high_word_o = 1'b1;
      end
      ALU_DIV: begin
        signed1_o = 1'b1;
        signed2_o = 1'b1;
      end
      ALU_DIVU: begin
        is_rem_o = 1'b0;
      end
      ALU_REM: begin
        is_rem_o  = 1'b1;
        signed1_o = 1'b1;
        signed2_o = 1'b1;
      end
      ALU_REMU: begin
        is_rem_o = 1'b1;
      end
      default: begin
        is_mul_o = 1'b0;
      end
    endcase
  end

  // Magnitudes and result sign; a remainder follows the dividend's sign.
  always_comb begin
    neg1_s       = signed1_o & op1_i[XLEN-1];
    neg2_s       = signed2_o & op2_i[XLEN-1];
    abs1_o       = neg1_s ? ((~op1_i) + XLEN'(1'b1)) : op1_i;
    abs2_o       = neg2_s ? ((~op2_i) + XLEN'(1'b1)) : op2_i;
    neg_result_o = is_rem_o ? neg1_s : (neg1_s ^ neg2_s);
  end

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// RV32M iterative multiply/divide unit with START/BUSY/DONE handshake.
// Multiply: radix-2 shift-add, one bit per cycle. Divide: restoring, one
// quotient bit per cycle. Divide-by-zero and signed overflow take a short
// path straight to FINISH.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a registered
// single-cycle signed 33x33 multiplier; division stays iterative.
module rv32m_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic [4:0]      ALU_CTRL,
  input  logic [XLEN-1:0] OPERAND1,
  input  logic [XLEN-1:0] OPERAND2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);
  import rv32im_pkg::*;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Multiply: {partial product hi, multiplier}. Divide: low half holds
  // the dividend shifting out and the quotient shifting in.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
  logic              neg_q, neg_d;
  logic              is_mul_q, is_mul_d;
  logic              is_rem_q, is_rem_d;
  logic              high_q, high_d;
  logic              fast_q, fast_d;
  logic [XLEN-1:0]   fast_res_q, fast_res_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  logic              prep_valid_s, prep_is_mul_s, prep_is_rem_s, prep_high_s;
  logic              prep_signed1_s, prep_signed2_s, prep_neg_s;
  logic [XLEN-1:0]   prep_abs1_s, prep_abs2_s;
  logic              overflow_s;

  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_shift_s;
  logic [XLEN:0]     div_diff_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s;
  logic [XLEN-1:0]   rem_fix_s;

`ifdef MULDIV_FAST_MUL_EN
  logic [XLEN:0]     fa_q, fa_d;
  logic [XLEN:0]     fb_q, fb_d;
  logic [2*XLEN-1:0] fast_prod_s;
`endif

  muldiv_sign_prep u_sign_prep (
    .alu_ctrl_i   (ALU_CTRL),
    .op1_i        (OPERAND1),
    .op2_i        (OPERAND2),
    .valid_o      (prep_valid_s),
    .is_mul_o     (prep_is_mul_s),
    .is_rem_o     (prep_is_rem_s),
    .high_word_o  (prep_high_s),
    .signed1_o    (prep_signed1_s),
    .signed2_o    (prep_signed2_s),
    .neg_result_o (prep_neg_s),
    .abs1_o       (prep_abs1_s),
    .abs2_o       (prep_abs2_s)
  );

  // Iteration step datapath and final sign correction.
  always_comb begin
    overflow_s  = ~prep_is_mul_s & prep_signed1_s & prep_signed2_s &
                  (OPERAND1 == INT_MIN) & (OPERAND2 == ALL_ONES);
    mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
    div_shift_s = {rem_q, acc_q[XLEN-1]};
    div_diff_s  = div_shift_s - {1'b0, opb_q};
    prod_fix_s  = neg_q ? ((~acc_q) + (2*XLEN)'(1'b1)) : acc_q;
    quo_fix_s   = neg_q ? ((~acc_q[XLEN-1:0]) + XLEN'(1'b1)) : acc_q[XLEN-1:0];
    rem_fix_s   = neg_q ? ((~rem_q) + XLEN'(1'b1)) : rem_q;
  end

`ifdef MULDIV_FAST_MUL_EN
  // Signed 33x33 product of the latched sign-extended operands.
  always_comb begin
    fast_prod_s = $signed({{(XLEN-1){fa_q[XLEN]}}, fa_q}) *
                  $signed({{(XLEN-1){fb_q[XLEN]}}, fb_q});
  end
`endif

  // Next-state and datapath update; FLUSH overrides every state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    opb_d      = opb_q;
    neg_d      = neg_q;
    is_mul_d   = is_mul_q;
    is_rem_d   = is_rem_q;
    high_d     = high_q;
    fast_d     = fast_q;
    fast_res_d = fast_res_q;
    result_d   = result_q;
    done_d     = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
    fa_d       = fa_q;
    fb_d       = fb_q;
`endif
    if (FLUSH) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (START && prep_valid_s) begin
            is_mul_d   = prep_is_mul_s;
            is_rem_d   = prep_is_rem_s;
            high_d     = prep_high_s;
            cnt_d      = CNT_W'(XLEN-1);
            rem_d      = {XLEN{1'b0}};
            acc_d      = {{XLEN{1'b0}}, (prep_is_mul_s ? prep_abs2_s : prep_abs1_s)};
            opb_d      = prep_is_mul_s ? prep_abs1_s : prep_abs2_s;
            fast_d     = 1'b0;
            fast_res_d = fast_res_q;
`ifdef MULDIV_FAST_MUL_EN
            // The signed multiplier produces the correctly signed product.
            neg_d      = prep_is_mul_s ? 1'b0 : prep_neg_s;
            fa_d       = {prep_signed1_s & OPERAND1[XLEN-1], OPERAND1};
            fb_d       = {prep_signed2_s & OPERAND2[XLEN-1], OPERAND2};
`else
            neg_d      = prep_neg_s;
`endif
            if (!prep_is_mul_s && (OPERAND2 == {XLEN{1'b0}})) begin
              fast_d     = 1'b1;
              fast_res_d = prep_is_rem_s ? OPERAND1 : ALL_ONES;
              state_d    = FINISH;
            end else if (overflow_s) begin
              fast_d     = 1'b1;
              fast_res_d = prep_is_rem_s ? {XLEN{1'b0}} : INT_MIN;
              state_d    = FINISH;
            end else begin
              state_d    = CALC;
            end
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
`ifdef MULDIV_FAST_MUL_EN
          if (is_mul_q) begin
            acc_d   = fast_prod_s;
            state_d = FINISH;
          end else
`endif
          begin
            if (is_mul_q) begin
              acc_d = acc_q[0] ? {mul_sum_s, acc_q[XLEN-1:1]}
                               : {1'b0, acc_q[2*XLEN-1:1]};
            end else begin
              rem_d = div_diff_s[XLEN] ? div_shift_s[XLEN-1:0] : div_diff_s[XLEN-1:0];
              acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_diff_s[XLEN]};
            end
            cnt_d = cnt_q - CNT_W'(1'b1);
            if (cnt_q == {CNT_W{1'b0}}) begin
              state_d = FINISH;
            end else begin
              state_d = CALC;
            end
          end
        end
        FINISH: begin
          if (fast_q) begin
            result_d = fast_res_q;
          end else if (is_mul_q) begin
            result_d = high_q ? prod_fix_s[2*XLEN-1:XLEN] : prod_fix_s[XLEN-1:0];
          end else if (is_rem_q) begin
            result_d = rem_fix_s;
          end else begin
            result_d = quo_fix_s;
          end
          done_d  = 1'b1;
          fast_d  = 1'b0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // FSM state and handshake registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      done_q   <= 1'b0;
      result_q <= {XLEN{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Operand, accumulator and op-flag registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      acc_q      <= {(2*XLEN){1'b0}};
      rem_q      <= {XLEN{1'b0}};
      opb_q      <= {XLEN{1'b0}};
      neg_q      <= 1'b0;
      is_mul_q   <= 1'b0;
      is_rem_q   <= 1'b0;
      high_q     <= 1'b0;
      fast_q     <= 1'b0;
      fast_res_q <= {XLEN{1'b0}};
`ifdef MULDIV_FAST_MUL_EN
      fa_q       <= {(XLEN+1){1'b0}};
      fb_q       <= {(XLEN+1){1'b0}};
`endif
    end else begin
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      opb_q      <= opb_d;
      neg_q      <= neg_d;
      is_mul_q   <= is_mul_d;
      is_rem_q   <= is_rem_d;
      high_q     <= high_d;
      fast_q     <= fast_d;
      fast_res_q <= fast_res_d;
`ifdef MULDIV_FAST_MUL_EN
      fa_q       <= fa_d;
      fb_q       <= fb_d;
`endif
    end
  end

  assign BUSY   = (state_q != IDLE);
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Self-checking bench for rv32m_muldiv_unit: directed cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_rv32m_muldiv_unit;

  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;
  localparam logic [31:0] MIN32    = 32'h8000_0000;
  localparam logic [31:0] ONES32   = 32'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic        FLUSH = 1'b0;
  logic [4:0]  ALU_CTRL = 5'd0;
  logic [31:0] OPERAND1 = 32'd0;
  logic [31:0] OPERAND2 = 32'd0;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res = 32'd0;

  always #5 CLK = ~CLK;

  rv32m_muldiv_unit dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .START    (START),
    .ALU_CTRL (ALU_CTRL),
    .OPERAND1 (OPERAND1),
    .OPERAND2 (OPERAND2),
    .FLUSH    (FLUSH),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .RESULT   (RESULT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result straight from the RISC-V M definitions.
  function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (op)
      OP_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
      OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      OP_DIV:    begin
        if (b == 32'd0) return ONES32;
        if (a == MIN32 && b == ONES32) return MIN32;
        return 32'(sa / sb);
      end
      OP_DIVU:   return (b == 32'd0) ? ONES32 : a / b;
      OP_REM:    begin
        if (b == 32'd0) return a;
        if (a == MIN32 && b == ONES32) return 32'd0;
        return 32'(sa % sb);
      end
      OP_REMU:   return (b == 32'd0) ? a : a % b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= OP_DIV) begin
      if (b == 32'd0) return 1;
      if ((op == OP_DIV || op == OP_REM) && a == MIN32 && b == ONES32) return 1;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 2;
`else
    return 33;
`endif
  endfunction

  // One operation; optionally pokes a second START while busy at poke_k.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int poke_k);
    int lat;
    logic busy_ok;
    logic [31:0] exp;
    exp = ref_model(op, a, b);
    @(negedge CLK);
    ALU_CTRL = op; OPERAND1 = a; OPERAND2 = b; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    busy_ok = (BUSY === 1'b1);
    lat = 0;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1) begin
        lat = k;
        if (BUSY !== 1'b0) busy_ok = 1'b0;
      end else if (BUSY !== 1'b1) begin
        busy_ok = 1'b0;
      end
      if (k == poke_k) begin
        ALU_CTRL = OP_MUL; OPERAND1 = 32'd3; OPERAND2 = 32'd3; START = 1'b1;
      end else begin
        START = 1'b0;
      end
    end
    START = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(ref_latency(op, a, b)));
    check({tag, " result"}, RESULT, exp);
    check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    @(posedge CLK); #1;
    check({tag, " done pulse"}, {31'd0, DONE}, 32'd0);
    last_res = exp;
  endtask

  initial begin
    int saw_done;
    logic [4:0]  rop;
    logic [31:0] ra, rb;

    // Reset state
    #2;
    check("reset busy", {31'd0, BUSY}, 32'd0);
    check("reset done", {31'd0, DONE}, 32'd0);
    check("reset result", RESULT, 32'd0);
    @(negedge CLK); RESET_N = 1'b1;

    // Directed cases
    run_op("MUL 7*-3", OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 0);
    check("MUL 7*-3 const", last_res, 32'hFFFF_FFEB);
    run_op("MULH min*min", OP_MULH, MIN32, MIN32, 0);
    run_op("MULHU ones", OP_MULHU, ONES32, ONES32, 0);
    run_op("MULHSU -1*2", OP_MULHSU, ONES32, 32'd2, 0);
    run_op("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 0);
    run_op("REMU 100/7", OP_REMU, 32'd100, 32'd7, 0);
    run_op("DIV 5/0", OP_DIV, 32'd5, 32'd0, 0);
    run_op("REM 5/0", OP_REM, 32'd5, 32'd0, 0);
    run_op("DIVU 5/0", OP_DIVU, 32'd5, 32'd0, 0);
    run_op("REMU 5/0", OP_REMU, 32'd5, 32'd0, 0);
    run_op("DIV ovf", OP_DIV, MIN32, ONES32, 0);
    run_op("REM ovf", OP_REM, MIN32, ONES32, 0);
    run_op("MUL 0x12345678*16", OP_MUL, 32'h1234_5678, 32'h0000_0010, 0);
    run_op("START while busy", OP_DIVU, 32'd100, 32'd7, 5);

    // FLUSH at edge 10 of a DIV
    @(negedge CLK);
    ALU_CTRL = OP_DIV; OPERAND1 = 32'd1000; OPERAND2 = 32'd3; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    repeat (9) @(posedge CLK);
    #1; FLUSH = 1'b1;
    @(posedge CLK); #1; FLUSH = 1'b0;
    check("flush busy", {31'd0, BUSY}, 32'd0);
    saw_done = 0;
    repeat (40) begin @(posedge CLK); #1; if (DONE === 1'b1) saw_done++; end
    check("flush no done", 32'(saw_done), 32'd0);
    check("flush result kept", RESULT, last_res);

    // FLUSH together with START in IDLE
    @(negedge CLK);
    ALU_CTRL = OP_DIVU; OPERAND1 = 32'd9; OPERAND2 = 32'd0; START = 1'b1; FLUSH = 1'b1;
    @(posedge CLK); #1; START = 1'b0; FLUSH = 1'b0;
    check("flush+start busy", {31'd0, BUSY}, 32'd0);
    saw_done = 0;
    repeat (4) begin @(posedge CLK); #1; if (DONE === 1'b1) saw_done++; end
    check("flush+start no done", 32'(saw_done), 32'd0);

    // Invalid op code
    @(negedge CLK);
    ALU_CTRL = 5'b00010; OPERAND1 = 32'd4; OPERAND2 = 32'd4; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    check("invalid busy", {31'd0, BUSY}, 32'd0);
    saw_done = 0;
    repeat (4) begin @(posedge CLK); #1; if (DONE === 1'b1) saw_done++; end
    check("invalid no done", 32'(saw_done), 32'd0);
    check("invalid result kept", RESULT, last_res);

    // Asynchronous reset at edge 20 of a MUL
    @(negedge CLK);
    ALU_CTRL = OP_MUL; OPERAND1 = 32'd12345; OPERAND2 = 32'd678; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    repeat (20) @(posedge CLK);
    #2; RESET_N = 1'b0;
    #1;
    check("async reset busy", {31'd0, BUSY}, 32'd0);
    check("async reset done", {31'd0, DONE}, 32'd0);
    check("async reset result", RESULT, 32'd0);
    @(negedge CLK); RESET_N = 1'b1;
    last_res = 32'd0;
    run_op("after reset REMU", OP_REMU, 32'd1001, 32'd10, 0);

    // Random operations
    for (int i = 0; i < 48; i++) begin
      rop = 5'(10 + $urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: ra = 32'd0;
        1: ra = MIN32;
        2: ra = ONES32;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = ONES32;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
